// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 fetch path: PC mux selects and fetch FSM states.
package msrv32_pkg;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  // The boot code never needs to be queued, so it doubles as "nothing pending".
  localparam logic [1:0] PENDING_NONE = PC_SRC_BOOT;

  typedef enum logic [1:0] {
    FETCH_BOOT     = 2'b00,
    FETCH_RUN      = 2'b01,
    FETCH_STALL    = 2'b10,
    FETCH_REDIRECT = 2'b11
  } fetch_state_e;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/msrv32_fetch_perf_cnt.sv
// Free-running fetch/stall event counters, wrapping at 2^32.
module msrv32_fetch_perf_cnt
  import msrv32_pkg::*;
(
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  fetch_inc,
  input  logic                  stall_inc,
  output logic [PERF_CNT_W-1:0] fetch_count,
  output logic [PERF_CNT_W-1:0] stall_count
);

  logic [1:0]            inc;
  logic [PERF_CNT_W-1:0] count_reg [2];

  assign inc = {stall_inc, fetch_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (srst) begin
          count_reg[gi] <= '0;
        end else if (inc[gi]) begin
          count_reg[gi] <= count_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign fetch_count = count_reg[0];
  assign stall_count = count_reg[1];

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// Instruction fetch controller: boot, sequential fetch, stall and trap/mret redirect.
// Optional counters enabled by defining MSRV32_FETCH_PERF_EN.
module msrv32_fetch_ctrl
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ahb_ready_in,
  input  logic        trap_taken_in,
  input  logic        mret_in,
  input  logic        misaligned_instr_in,
  input  logic [31:0] pc_mux_in,
  output logic [1:0]  pc_src_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out,
  output logic        trap_req_out
`ifdef MSRV32_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count_out,
  output logic [31:0] stall_count_out
`endif
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [1:0]   pending_reg, pending_next;
  logic         instr_valid_reg, instr_valid_next;
  logic         flush_reg, flush_next;
  logic         trap_req_reg, trap_req_next;
  logic [1:0]   pc_src;

  // A queued redirect outranks whatever trap/mret is on the inputs this cycle.
  always_comb begin
    pc_src = PC_SRC_NEXT;
    if (state_reg == FETCH_BOOT) begin
      pc_src = PC_SRC_BOOT;
    end else if (pending_reg != PENDING_NONE) begin
      pc_src = pending_reg;
    end else if (trap_taken_in) begin
      pc_src = PC_SRC_TRAP;
    end else if (mret_in) begin
      pc_src = PC_SRC_EPC;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pending_next     = pending_reg;
    instr_valid_next = 1'b0;
    flush_next       = 1'b0;
    trap_req_next    = 1'b0;

    if (state_reg == FETCH_BOOT) begin
      if (ahb_ready_in) begin
        pc_next    = BOOT_ADDRESS;
        state_next = FETCH_RUN;
      end
    end else if (!ahb_ready_in) begin
      state_next = FETCH_STALL;
      if (trap_taken_in) begin
        pending_next = PC_SRC_TRAP;
      end else if (mret_in && pending_reg != PC_SRC_TRAP) begin
        pending_next = PC_SRC_EPC;
      end
    end else if (pc_src != PC_SRC_NEXT) begin
      pc_next      = pc_mux_in;
      state_next   = FETCH_REDIRECT;
      flush_next   = 1'b1;
      pending_next = PENDING_NONE;
    end else if (misaligned_instr_in) begin
      // Keep the last good PC; the CSR unit takes the trap from here.
      state_next    = FETCH_RUN;
      trap_req_next = 1'b1;
    end else begin
      pc_next          = pc_mux_in;
      state_next       = FETCH_RUN;
      instr_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg       <= FETCH_BOOT;
      pc_reg          <= BOOT_ADDRESS;
      pending_reg     <= PENDING_NONE;
      instr_valid_reg <= 1'b0;
      flush_reg       <= 1'b1;
      trap_req_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pending_reg     <= pending_next;
      instr_valid_reg <= instr_valid_next;
      flush_reg       <= flush_next;
      trap_req_reg    <= trap_req_next;
    end
  end

  assign pc_src_out      = pc_src;
  assign pc_out          = pc_reg;
  assign instr_valid_out = instr_valid_reg;
  assign flush_out       = flush_reg;
  assign trap_req_out    = trap_req_reg;

`ifdef MSRV32_FETCH_PERF_EN
  msrv32_fetch_perf_cnt u_perf_cnt (
    .clk         (clk_in),
    .srst        (rst_in),
    .fetch_inc   (instr_valid_reg),
    .stall_inc   (state_reg == FETCH_STALL),
    .fetch_count (fetch_count_out),
    .stall_count (stall_count_out)
  );
`endif

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Directed + randomized bench for msrv32_fetch_ctrl against a cycle-level reference model.
module tb_msrv32_fetch_ctrl;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, ready, trap, mret, mis;
  logic [31:0] pc_mux;
  logic [1:0]  pc_src;
  logic [31:0] pc;
  logic        iv, flush, treq;
`ifdef MSRV32_FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: plain flags describing where the fetch unit is.
  bit          m_init = 0;
  bit          m_booting, m_stalled, m_pend_trap, m_pend_mret;
  logic [31:0] m_pc;
  bit          m_iv, m_flush, m_treq;
  logic [31:0] m_fetch_cnt, m_stall_cnt;

  msrv32_fetch_ctrl #(.BOOT_ADDRESS(BOOT)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .ahb_ready_in        (ready),
    .trap_taken_in       (trap),
    .mret_in             (mret),
    .misaligned_instr_in (mis),
    .pc_mux_in           (pc_mux),
    .pc_src_out          (pc_src),
    .pc_out              (pc),
    .instr_valid_out     (iv),
    .flush_out           (flush),
    .trap_req_out        (treq)
`ifdef MSRV32_FETCH_PERF_EN
    ,
    .fetch_count_out     (fetch_cnt),
    .stall_count_out     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mux select the spec's priority rules demand for the current inputs.
  function automatic logic [1:0] model_src();
    if (m_booting)   return 2'd0;
    if (m_pend_trap) return 2'd2;
    if (m_pend_mret) return 2'd1;
    if (trap)        return 2'd2;
    if (mret)        return 2'd1;
    return 2'd3;
  endfunction

  task automatic model_step();
    logic [1:0] src;
    src = model_src();
    if (rst) begin
      m_init = 1; m_booting = 1; m_stalled = 0;
      m_pend_trap = 0; m_pend_mret = 0;
      m_pc = BOOT; m_iv = 0; m_flush = 1; m_treq = 0;
      m_fetch_cnt = 0; m_stall_cnt = 0;
      return;
    end
    m_fetch_cnt += 32'(m_iv);
    m_stall_cnt += 32'(m_stalled);
    m_iv = 0; m_flush = 0; m_treq = 0;
    if (m_booting) begin
      if (ready) begin
        m_pc = BOOT;
        m_booting = 0;
      end
    end else if (!ready) begin
      m_stalled = 1;
      if (trap) begin
        m_pend_trap = 1;
        m_pend_mret = 0;
      end else if (mret && !m_pend_trap) begin
        m_pend_mret = 1;
      end
    end else begin
      m_stalled = 0;
      if (src != 2'd3) begin
        m_pc = pc_mux;
        m_flush = 1;
        m_pend_trap = 0;
        m_pend_mret = 0;
      end else if (mis) begin
        m_treq = 1;
      end else begin
        m_pc = pc_mux;
        m_iv = 1;
      end
    end
  endtask

  // One clock: apply inputs, check the combinational select, clock, check registered outputs.
  task automatic drive(input bit r, input bit rd, input bit t, input bit m, input bit mi,
                       input logic [31:0] pm);
    rst = r; ready = rd; trap = t; mret = m; mis = mi; pc_mux = pm;
    #1;
    if (m_init) check("pc_src", 32'(pc_src), 32'(model_src()));
    @(posedge clk);
    model_step();
    #1;
    check("pc_out", pc, m_pc);
    check("instr_valid", 32'(iv), 32'(m_iv));
    check("flush", 32'(flush), 32'(m_flush));
    check("trap_req", 32'(treq), 32'(m_treq));
`ifdef MSRV32_FETCH_PERF_EN
    check("fetch_count", fetch_cnt, m_fetch_cnt);
    check("stall_count", stall_cnt, m_stall_cnt);
`endif
    $display("cyc t=%0t rst=%0b rdy=%0b trap=%0b mret=%0b mis=%0b mux=%h -> src=%0d pc=%h iv=%0b fl=%0b tr=%0b",
             $time, r, rd, t, m, mi, pm, pc_src, pc, iv, flush, treq);
  endtask

  initial begin
    rst = 1; ready = 1; trap = 0; mret = 0; mis = 0; pc_mux = '0;
    @(negedge clk);

    // Reset then boot
    drive(1, 1, 0, 0, 0, 32'h0);
    drive(1, 1, 0, 0, 0, 32'h0);
    check("reset_flush", 32'(flush), 32'd1);
    drive(0, 1, 0, 0, 0, 32'h0);
    check("boot_pc", pc, 32'h100);
    check("boot_flush_low", 32'(flush), 32'd0);

    // Sequential fetch
    drive(0, 1, 0, 0, 0, 32'h104);
    check("seq_pc_104", pc, 32'h104);
    check("seq_valid", 32'(iv), 32'd1);
    drive(0, 1, 0, 0, 0, 32'h108);
    check("seq_pc_108", pc, 32'h108);

    // Stall with trap in the middle cycle, then redirect
    drive(0, 0, 0, 0, 0, 32'h200);
    drive(0, 0, 1, 0, 0, 32'h200);
    drive(0, 0, 0, 0, 0, 32'h200);
    check("stall_pc_held", pc, 32'h108);
    check("stall_pending_src", 32'(pc_src), 32'd2);
    drive(0, 1, 0, 0, 0, 32'h8000_0000);
    check("redirect_pc", pc, 32'h8000_0000);
    check("redirect_flush", 32'(flush), 32'd1);
    drive(0, 1, 0, 0, 0, 32'h8000_0004);
    check("redirect_one_cycle", 32'(flush), 32'd0);

    // Trap and mret together
    rst = 0; trap = 1; mret = 1; #1;
    check("trap_over_mret_src", 32'(pc_src), 32'd2);
    drive(0, 1, 1, 1, 0, 32'h40);
    check("trap_over_mret_pc", pc, 32'h40);
    drive(0, 1, 0, 0, 0, 32'h44);

    // Misaligned target
    drive(0, 1, 0, 0, 1, 32'h46);
    check("misaligned_pc_hold", pc, 32'h44);
    check("misaligned_trap_req", 32'(treq), 32'd1);
    drive(0, 1, 0, 0, 0, 32'h48);
    check("misaligned_pulse_end", 32'(treq), 32'd0);

    // Trap and misaligned together: trap wins, no pulse
    drive(0, 1, 1, 0, 1, 32'h80);
    check("trap_over_mis_req", 32'(treq), 32'd0);

    // Reset during stall with pending mret
    drive(0, 0, 0, 0, 0, 32'h300);
    drive(0, 0, 0, 1, 0, 32'h300);
    drive(1, 0, 0, 0, 0, 32'h300);
    check("reset_stall_src", 32'(pc_src), 32'd0);
    drive(0, 1, 0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 0, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 0, 32'h0000_0000);
    check("wrap_pc", pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(49) == 0),
            ($urandom_range(3) != 0),
            ($urandom_range(9) == 0),
            ($urandom_range(9) == 0),
            ($urandom_range(7) == 0),
            ($urandom_range(3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
